// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and counter sizing for the PISO serializer.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: mod-N up-counter with synchronous clear, enable and terminal count.
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = cnt_w(N);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: captures an N-bit word on load&ready and shifts it out one bit per clock,
// with gapless back-to-back words and a done pulse after each word's last bit.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] I,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         done,
    output logic [N-1:0] Q
);

    state_t       r_state;
    logic [N-1:0] r_sh;
    logic         r_done;
    logic         w_tc;
    logic         w_shift;
    logic         w_accept;

    assign w_shift    = (r_state == SHIFT);
    assign ready      = !w_shift || w_tc;
    assign w_accept   = load && ready;
    assign sout_valid = w_shift;
    assign sout       = w_shift && (MSB_FIRST ? r_sh[N-1] : r_sh[0]);
    assign done       = r_done;
    assign Q          = r_sh;

    bit_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  (w_shift),
        .o_tc  (w_tc)
    );

    // A load on the last bit reloads instead of shifting, keeping words gapless.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_shift && w_tc;
            if (w_accept) begin
                r_sh    <= I;
                r_state <= SHIFT;
            end else if (w_shift) begin
                r_sh <= MSB_FIRST ? {r_sh[N-2:0], 1'b0} : {1'b0, r_sh[N-1:1]};
                if (w_tc)
                    r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first and LSB-first instances share stimulus and are checked
// against a per-cycle timeline of expected outputs built from each accepted word.
module tb_piso_serializer;

    localparam int N     = 4;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         reset, load;
    logic [N-1:0] I;
    logic         rdy_m, sout_m, val_m, done_m;
    logic         rdy_l, sout_l, val_l, done_l;
    logic [N-1:0] q_m, q_l;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic         e_val  [2][DEPTH];
    logic         e_sout [2][DEPTH];
    logic         e_last [2][DEPTH];
    logic         e_done [2][DEPTH];
    logic [N-1:0] e_q    [2][DEPTH];

    always #5 clk = ~clk;

    piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load(load), .I(I), .ready(rdy_m),
        .sout(sout_m), .sout_valid(val_m), .done(done_m), .Q(q_m)
    );

    piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(load), .I(I), .ready(rdy_l),
        .sout(sout_l), .sout_valid(val_l), .done(done_l), .Q(q_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic exp_ready(input int d, input int c);
        return !e_val[d][c] || e_last[d][c];
    endfunction

    task automatic step(input logic rs, input logic ld, input logic [N-1:0] w);
        logic acc;
        reset = rs;
        load  = ld;
        I     = w;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            acc = !rs && ld && exp_ready(d, cyc - 1);
            if (rs)
                for (int c = cyc; c < DEPTH; c++) begin
                    e_val[d][c]  = 1'b0;
                    e_sout[d][c] = 1'b0;
                    e_last[d][c] = 1'b0;
                    e_done[d][c] = 1'b0;
                    e_q[d][c]    = '0;
                end
            else if (acc) begin
                for (int j = 0; j < N; j++) begin
                    e_val[d][cyc+j]  = 1'b1;
                    e_sout[d][cyc+j] = (d == 0) ? w[N-1-j] : w[j];
                    e_last[d][cyc+j] = (j == N - 1);
                    e_q[d][cyc+j]    = (d == 0) ? (w << j) : (w >> j);
                end
                e_q[d][cyc+N]    = '0;
                e_done[d][cyc+N] = 1'b1;
            end
        end
        #1;
        check("msb_sout",  32'(sout_m), 32'(e_sout[0][cyc]));
        check("msb_valid", 32'(val_m),  32'(e_val[0][cyc]));
        check("msb_done",  32'(done_m), 32'(e_done[0][cyc]));
        check("msb_ready", 32'(rdy_m),  32'(exp_ready(0, cyc)));
        check("msb_q",     32'(q_m),    32'(e_q[0][cyc]));
        check("lsb_sout",  32'(sout_l), 32'(e_sout[1][cyc]));
        check("lsb_valid", 32'(val_l),  32'(e_val[1][cyc]));
        check("lsb_done",  32'(done_l), 32'(e_done[1][cyc]));
        check("lsb_ready", 32'(rdy_l),  32'(exp_ready(1, cyc)));
        check("lsb_q",     32'(q_l),    32'(e_q[1][cyc]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, '0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < DEPTH; c++) begin
                e_val[d][c]  = 1'b0;
                e_sout[d][c] = 1'b0;
                e_last[d][c] = 1'b0;
                e_done[d][c] = 1'b0;
                e_q[d][c]    = '0;
            end
        reset = 1'b1;
        load  = 1'b0;
        I     = '0;
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        // single word, both bit orders
        step(1'b0, 1'b1, 4'b1011);
        idle(6);
        // back-to-back words with load asserted on the last bit
        step(1'b0, 1'b1, 4'b1011);
        idle(3);
        step(1'b0, 1'b1, 4'b0110);
        idle(6);
        // load while busy is ignored
        step(1'b0, 1'b1, 4'b1011);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 4'b0000);
        idle(5);
        // reset mid-word aborts without done
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(5);
        // reset wins over load on the same edge
        step(1'b1, 1'b1, 4'b1111);
        idle(5);
        // held load gives continuous words
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, 4'($urandom));
        idle(5);
        for (int i = 0; i < 350; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, 4'($urandom));
        idle(6);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer: the unload side of the loadable N-bit register. It captures an N-bit word on a load handshake and shifts it out one bit per clock, MSB-first or LSB-first. It asserts a valid flag during each bit and pulses `done` after the last bit of every word. It sits between a parallel register stage and any single-wire serial consumer, and it supports gapless back-to-back words.

## Interface
- `N`, default 4: word width; N >= 2.
- `MSB_FIRST`, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; takes effect on the rising edge of `clk`.
- `load`  in  1  request to capture `I`; accepted only when `load && ready` at a clock edge.
- `I`  in  N  parallel word to serialize.
- `ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` carries a word bit this cycle.
- `done`  out  1  one-cycle pulse in the cycle after the last bit of a word.
- `Q`  out  N  current shift-register contents, for observation only.

## Operation
- States: IDLE and SHIFT. Registers: state, shift register `sh[N-1:0]`, bit counter `cnt` of width clog2(N), and `done`.
- **IDLE**
  - `ready`=1, `sout_valid`=0, `sout`=0.
  - On `load`: `sh`<=`I`, `cnt`<=0, go to SHIFT.
- **SHIFT**
  - `sout_valid`=1.
  - `sout` = `sh[N-1]` if MSB_FIRST, else `sh[0]`.
  - Each edge: shift one position toward the output end, zero-fill the vacated bit, `cnt`<=`cnt`+1.
- **Last bit** (SHIFT and `cnt`==N-1)
  - `ready`=1.
  - With `load`: `sh`<=`I`, `cnt`<=0, stay in SHIFT (gapless).
  - Without `load`: go to IDLE.
  - Either way, `done`<=1 for the next cycle.
- **Load while busy:** `load` in SHIFT with `cnt`<N-1 is ignored. `ready`=0, so no capture occurs and no error is flagged.
- **Output decode:** `ready`, `sout` and `sout_valid` are combinational decodes of registered state. There are no input-to-output combinational paths.
- **`done` register:** default 0 each cycle; set only at a last-bit edge.

## Timing
- **Reset values:** state=IDLE, `sh`=0, `cnt`=0, `done`=0. Hence `ready`=1, `sout`=0, `sout_valid`=0, `Q`=0.
- **Latency:** a load accepted at edge k puts the first bit on `sout` in cycle k+1. Bit j (0-based, in send order) appears in cycle k+1+j. `done` is high in cycle k+N+1 only.
- **Throughput:** one word per N cycles when `load` is held. There is no idle gap between words.
- **Gapless overlap:** when words overlap, `done` for word A coincides with bit 0 of word B.
- **Reset mid-word:** the word is aborted. Next cycle shows reset values, and no `done` is produced for the aborted word.
- **`reset` and `load` on the same edge:** `reset` wins and the word is not captured.
- **Wrap-around:** `cnt` never exceeds N-1; it reloads to 0 on every accepted load.

## Structure
- **Shared package:** state encoding constants (IDLE, SHIFT) and a clog2-based counter-width constant function for `cnt`.
- **Sub-module `bit_counter`:** a mod-N up-counter with synchronous clear, enable, and a terminal-count output `tc` (`cnt`==N-1). The FSM drives its clear from an accepted load and its enable from SHIFT. The shift register and FSM stay in the top module.

## Test plan
- **MSB-first word:** N=4, MSB_FIRST=1; load `I`=4'b1011 from IDLE at edge 0.
  - `sout` = 1,0,1,1 in cycles 1–4 with `sout_valid`=1.
  - `done`=1 in cycle 5 only; `ready`=0 in cycles 1–3.
- **LSB-first word:** MSB_FIRST=0; load 4'b1011.
  - `sout` = 1,1,0,1 in cycles 1–4; `done` in cycle 5.
- **Back-to-back:** load 4'b1011, then assert `load` with 4'b0110 in cycle 4 (`ready`=1 there).
  - 8 contiguous valid bits: 1,0,1,1,0,1,1,0.
  - `done` in cycles 5 and 9; `sout_valid` never drops between words.
- **Load while busy:** during the word 4'b1011, pulse `load` with 4'b0000 in cycle 2.
  - Output is still 1,0,1,1; returns to IDLE after cycle 4.
- **Reset mid-word:** assert `reset` in cycle 2 of word 4'b1111.
  - Cycle 3: `sout`=0, `sout_valid`=0, `ready`=1, `Q`=0.
  - No `done` pulse follows.
- **Reset vs load:** assert `reset` and `load` (`I`=4'b1111) on the same edge.
  - Block stays in IDLE with `Q`=0; no bits are emitted.
